// File: rtl/bitcoin_nonce_select.sv
// Scans NUM_NONCES h0 words in shared memory, keeps the smallest, and writes
// a two-word summary (best hash, then found flag plus nonce index) back to memory.
module bitcoin_nonce_select #(
  parameter int unsigned NUM_NONCES = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] input_addr,
  input  logic [15:0] result_addr,
  input  logic [31:0] target,
  output logic        done,
  output logic        found,
  output logic [7:0]  best_nonce,
  output logic [31:0] best_hash,
  output logic        mem_clk,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  localparam logic [8:0] LastIdx = 9'(NUM_NONCES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StRdAddr,
    StRdWait,
    StRdCap,
    StWrHash,
    StWrFlags,
    StFinish
  } state_e;

  state_e      state_q, state_d;
  logic [8:0]  idx_q, idx_d;
  logic [31:0] run_best_q, run_best_d;
  logic [7:0]  run_idx_q, run_idx_d;
  logic [31:0] target_q, target_d;
  logic        mem_we_q, mem_we_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        done_q, done_d;
  logic        found_q, found_d;
  logic [7:0]  best_nonce_q, best_nonce_d;
  logic [31:0] best_hash_q, best_hash_d;
  logic        found_n;

  assign found_n = (run_best_q < target_q);

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    run_best_d   = run_best_q;
    run_idx_d    = run_idx_q;
    target_d     = target_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    found_d      = found_q;
    best_nonce_d = best_nonce_q;
    best_hash_d  = best_hash_q;
    // done is registered from WR_FLAGS so it is high exactly while in FINISH.
    done_d       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          target_d   = target;
          idx_d      = '0;
          run_best_d = '1;
          run_idx_d  = '0;
          state_d    = StRdAddr;
        end
      end
      StRdAddr: begin
        mem_we_d   = 1'b0;
        mem_addr_d = input_addr + {7'd0, idx_q};
        state_d    = StRdWait;
      end
      StRdWait: begin
        state_d = StRdCap;
      end
      StRdCap: begin
        // Strict compare: on ties the earlier (lower) index is kept.
        if (mem_read_data < run_best_q) begin
          run_best_d = mem_read_data;
          run_idx_d  = idx_q[7:0];
        end
        if (idx_q == LastIdx) begin
          state_d = StWrHash;
        end else begin
          idx_d   = idx_q + 9'd1;
          state_d = StRdAddr;
        end
      end
      StWrHash: begin
        mem_we_d    = 1'b1;
        mem_addr_d  = result_addr;
        mem_wdata_d = run_best_q;
        state_d     = StWrFlags;
      end
      StWrFlags: begin
        mem_we_d     = 1'b1;
        mem_addr_d   = result_addr + 16'd1;
        mem_wdata_d  = {found_n, 23'd0, run_idx_q};
        best_hash_d  = run_best_q;
        best_nonce_d = run_idx_q;
        found_d      = found_n;
        done_d       = 1'b1;
        state_d      = StFinish;
      end
      StFinish: begin
        mem_we_d = 1'b0;
        state_d  = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      run_best_q   <= '1;
      run_idx_q    <= '0;
      target_q     <= '0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      done_q       <= 1'b0;
      found_q      <= 1'b0;
      best_nonce_q <= '0;
      best_hash_q  <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      run_best_q   <= run_best_d;
      run_idx_q    <= run_idx_d;
      target_q     <= target_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      done_q       <= done_d;
      found_q      <= found_d;
      best_nonce_q <= best_nonce_d;
      best_hash_q  <= best_hash_d;
    end
  end

  assign mem_clk        = clk;
  assign mem_we         = mem_we_q;
  assign mem_addr       = mem_addr_q;
  assign mem_write_data = mem_wdata_q;
  assign done           = done_q;
  assign found          = found_q;
  assign best_nonce     = best_nonce_q;
  assign best_hash      = best_hash_q;

endmodule

// File: tb/tb_bitcoin_nonce_select.sv
// Bench for bitcoin_nonce_select: behavioural min-search model, shared-memory model,
// per-cycle output compare, and literal pins for the directed scenarios.
module tb_bitcoin_nonce_select;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [15:0] input_addr;
  logic [15:0] result_addr;
  logic [31:0] target;
  logic        done;
  logic        found;
  logic [7:0]  best_nonce;
  logic [31:0] best_hash;
  logic        mem_clk;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  bitcoin_nonce_select #(.NUM_NONCES(16)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .input_addr     (input_addr),
    .result_addr    (result_addr),
    .target         (target),
    .done           (done),
    .found          (found),
    .best_nonce     (best_nonce),
    .best_hash      (best_hash),
    .mem_clk        (mem_clk),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data)
  );

  localparam int N = 16;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared memory: registered read (data valid two edges after address load).
  logic [31:0] mem [0:65535];
  logic [31:0] rd_q;
  always @(posedge clk) begin
    rd_q <= mem[mem_addr];
    if (mem_we) mem[mem_addr] = mem_write_data;
  end
  assign mem_read_data = rd_q;

  int checks = 0;
  int errors = 0;

  logic        exp_done  = 1'b0;
  logic        exp_we    = 1'b0;
  logic [31:0] exp_hash  = '0;
  logic [7:0]  exp_nonce = '0;
  logic        exp_found = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("done", {31'd0, done}, {31'd0, exp_done});
    chk("mem_we", {31'd0, mem_we}, {31'd0, exp_we});
    chk("best_hash", best_hash, exp_hash);
    chk("best_nonce", {24'd0, best_nonce}, {24'd0, exp_nonce});
    chk("found", {31'd0, found}, {31'd0, exp_found});
    chk("mem_clk", {31'd0, mem_clk}, {31'd0, clk});
  end

  // Minimum over the N words at ia..ia+N-1 (mod 2^16), first index wins ties.
  task automatic model(input logic [15:0] ia, output logic [31:0] h, output logic [7:0] n);
    h = 32'hFFFF_FFFF;
    n = 8'd0;
    for (int i = 0; i < N; i++) begin
      if (mem[16'(ia + 16'(i))] < h) begin
        h = mem[16'(ia + 16'(i))];
        n = 8'(i);
      end
    end
  endtask

  task automatic run_scan(input logic [15:0] ia, input logic [15:0] ra, input logic [31:0] tg,
                          input bit mid_start);
    logic [31:0] mh;
    logic [7:0]  mn;
    logic        mf;
    model(ia, mh, mn);
    mf = (mh < tg);
    @(posedge clk); #1;
    input_addr  = ia;
    result_addr = ra;
    target      = tg;
    start       = 1'b1;
    @(posedge clk); #1;   // edge k has sampled start
    start = 1'b0;
    for (int c = 1; c <= 3 * N + 1; c++) begin
      @(posedge clk); #1;
      start = mid_start && (c == 10 || c == 11 || c == 30);
    end
    start  = 1'b0;
    exp_we = 1'b1;        // after edge k+3N+1: hash write pending
    @(posedge clk); #1;   // after edge k+3N+2
    exp_done  = 1'b1;
    exp_hash  = mh;
    exp_nonce = mn;
    exp_found = mf;
    @(posedge clk); #1;   // after edge k+3N+3
    exp_done = 1'b0;
    exp_we   = 1'b0;
    chk("mem_hash_word", mem[ra], mh);
    chk("mem_flag_word", mem[16'(ra + 16'd1)], {mf, 23'd0, mn});
  endtask

  initial begin
    reset_n     = 1'b1;
    start       = 1'b0;
    input_addr  = '0;
    result_addr = '0;
    target      = '0;
    for (int a = 0; a < 65536; a++) mem[a] = 32'hF000_0000;
    #1 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // Descending data, nonce 15 smallest, found.
    for (int i = 0; i < N; i++) mem[16'h0100 + i] = 32'h8000_0000 - 32'(i) * 32'h0100_0000;
    run_scan(16'h0100, 16'h0200, 32'h7200_0000, 1'b0);
    chk("t1_hash_lit", mem[16'h0200], 32'h7100_0000);
    chk("t1_flag_lit", mem[16'h0201], 32'h8000_000F);
    chk("t1_nonce_lit", {24'd0, best_nonce}, 32'd15);
    chk("t1_found_lit", {31'd0, found}, 32'd1);

    // Target equal to minimum: strict compare gives not found.
    run_scan(16'h0100, 16'h0200, 32'h7100_0000, 1'b0);
    chk("t2_flag_lit", mem[16'h0201], 32'h0000_000F);
    chk("t2_found_lit", {31'd0, found}, 32'd0);

    // Duplicate minimum at 3 and 9.
    for (int i = 0; i < N; i++) mem[16'h0400 + i] = 32'h1000_0000 + 32'(i) * 32'h111;
    mem[16'h0403] = 32'h0000_1234;
    mem[16'h0409] = 32'h0000_1234;
    run_scan(16'h0400, 16'h0500, 32'h0000_1235, 1'b0);
    chk("t3_nonce_lit", {24'd0, best_nonce}, 32'd3);
    chk("t3_hash_lit", best_hash, 32'h0000_1234);
    chk("t3_flag_lit", mem[16'h0501], 32'h8000_0003);

    // All ones.
    for (int i = 0; i < N; i++) mem[16'h0600 + i] = 32'hFFFF_FFFF;
    run_scan(16'h0600, 16'h0700, 32'hFFFF_FFFF, 1'b0);
    chk("t4_hash_lit", mem[16'h0700], 32'hFFFF_FFFF);
    chk("t4_flag_lit", mem[16'h0701], 32'h0000_0000);
    chk("t4_nonce_lit", {24'd0, best_nonce}, 32'd0);

    // Address wrap on both reads and writes.
    for (int i = 0; i < N; i++) mem[16'(16'hFFFA + 16'(i))] = 32'h5000_0000 + 32'(i) * 32'h10;
    mem[16'h0002] = 32'h0000_0ABC;
    run_scan(16'hFFFA, 16'hFFFF, 32'h0000_1000, 1'b0);
    chk("t5_hash_lit", mem[16'hFFFF], 32'h0000_0ABC);
    chk("t5_flag_lit", mem[16'h0000], 32'h8000_0008);

    // Reset in the middle of a scan: outputs clear at once, no write issued.
    mem[16'h0300] = 32'hDEAD_BEEF;
    mem[16'h0301] = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    input_addr  = 16'h0100;
    result_addr = 16'h0300;
    target      = 32'h7200_0000;
    start       = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (19) @(posedge clk);
    #2 reset_n = 1'b0;
    exp_hash  = '0;
    exp_nonce = '0;
    exp_found = 1'b0;
    #1;
    chk("rst_best_hash", best_hash, 32'd0);
    chk("rst_best_nonce", {24'd0, best_nonce}, 32'd0);
    chk("rst_found", {31'd0, found}, 32'd0);
    chk("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
    chk("rst_mem_wdata", mem_write_data, 32'd0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (60) @(posedge clk);
    #1;
    chk("rst_no_write0", mem[16'h0300], 32'hDEAD_BEEF);
    chk("rst_no_write1", mem[16'h0301], 32'hDEAD_BEEF);

    // Normal scan after reset, with stray start pulses and target 0.
    run_scan(16'h0400, 16'h0300, 32'h0000_0000, 1'b1);
    chk("t6_found_lit", {31'd0, found}, 32'd0);
    chk("t6_flag_lit", mem[16'h0301], 32'h0000_0003);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
